// File: rtl/managed_banked_bias_memory_pkg.sv
// managed_banked_bias_memory_pkg: shared types, default geometry and lane-mask helper for the bias memory
package managed_banked_bias_memory_pkg;

  typedef enum logic [1:0] {IDLE, PEND, RDWAIT} spi_state_e;

  localparam int unsigned DEF_WORD_BIT_WIDTH = 64;
  localparam int unsigned DEF_MESSAGE_BIT_WIDTH = 32;
  localparam int unsigned DEF_ROWS_PER_BANK = 32;
  localparam int unsigned DEF_NUM_BANKS = 2;
  localparam int unsigned DEF_START_ADDRESS_BIT_WIDTH = 14;
  localparam int unsigned DEF_STARVE_LIMIT = 15;

  // SPI address is {pad, bank, row, chunk}; the chunk field sits at the bottom
  localparam int unsigned CHUNK_LSB = 0;
  localparam int unsigned MAX_WORD_BIT_WIDTH = 512;

  function automatic logic [MAX_WORD_BIT_WIDTH-1:0] chunk_mask(input int unsigned chunk, input int unsigned msg_bits);
    logic [MAX_WORD_BIT_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_WORD_BIT_WIDTH; i++) m[i] = (i / msg_bits) == chunk;
    return m;
  endfunction

endpackage

// File: rtl/managed_banked_bias_memory_sram.sv
// bias_bank_sram: single-port SRAM bank with bitmask write, 1-cycle held read and power-down
module bias_bank_sram #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             power_down_i,
  input  logic             cs_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // masked write or registered read; the read register holds until the next read
  always_ff @(posedge clk) begin
    if (cs_i && !power_down_i) begin
      if (we_i) mem_q[addr_i] <= (mem_q[addr_i] & ~mask_i) | (wdata_i & mask_i);
      else rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = power_down_i ? '0 : rdata_q;

endmodule

// File: rtl/managed_banked_bias_memory.sv
// managed_banked_bias_memory: power-gated banked bias store shared by a priority control port and a queued SPI port
module managed_banked_bias_memory
  import managed_banked_bias_memory_pkg::*;
#(
  parameter int unsigned WORD_BIT_WIDTH = DEF_WORD_BIT_WIDTH,
  parameter int unsigned MESSAGE_BIT_WIDTH = DEF_MESSAGE_BIT_WIDTH,
  parameter int unsigned ROWS_PER_BANK = DEF_ROWS_PER_BANK,
  parameter int unsigned NUM_BANKS = DEF_NUM_BANKS,
  parameter int unsigned START_ADDRESS_BIT_WIDTH = DEF_START_ADDRESS_BIT_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  localparam int unsigned CHUNKS = WORD_BIT_WIDTH / MESSAGE_BIT_WIDTH,
  localparam int unsigned CHUNK_BITS = $clog2(CHUNKS),
  localparam int unsigned ROW_BITS = $clog2(ROWS_PER_BANK),
  localparam int unsigned BANK_BITS = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned CTRL_ADDR_BITS = BANK_BITS + ROW_BITS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               global_power_down,
  input  logic [NUM_BANKS-1:0]               bank_power_down,
  input  logic                               spi_req_valid,
  output logic                               spi_req_ready,
  input  logic                               spi_req_write,
  input  logic                               spi_code_is_bias,
  input  logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address,
  input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
  output logic                               spi_rsp_valid,
  output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out,
  output logic                               spi_access_error,
  output logic                               ctrl_ready,
  input  logic                               ctrl_chip_select,
  input  logic                               ctrl_write_enable,
  input  logic [CTRL_ADDR_BITS-1:0]          ctrl_address,
  input  logic [WORD_BIT_WIDTH-1:0]          ctrl_data_in,
  input  logic [WORD_BIT_WIDTH-1:0]          ctrl_mask,
  output logic [WORD_BIT_WIDTH-1:0]          ctrl_data_out
);

  localparam int unsigned ROW_LSB = CHUNK_LSB + CHUNK_BITS;
  localparam int unsigned BANK_LSB = ROW_LSB + ROW_BITS;
  localparam int unsigned PAD_LSB = BANK_LSB + BANK_BITS;
  localparam int unsigned NB_EXT = 1 << BANK_BITS;
  localparam int unsigned WAIT_BITS = $clog2(STARVE_LIMIT + 1);

  spi_state_e state_q, state_d;
  logic [WAIT_BITS-1:0] wait_q, wait_d;
  logic spi_we_q, spi_rsp_valid_q, spi_err_q, ctrl_rd_q;
  logic [START_ADDRESS_BIT_WIDTH-1:0] spi_addr_q;
  logic [MESSAGE_BIT_WIDTH-1:0] spi_wdata_q, spi_data_q;
  logic [BANK_BITS-1:0] ctrl_bank_q;
  logic [WORD_BIT_WIDTH-1:0] ctrl_hold_q;

  logic [BANK_BITS-1:0] spi_bank, ctrl_bank;
  logic [ROW_BITS-1:0] spi_row, ctrl_row, bank_row;
  logic [CHUNK_BITS-1:0] spi_chunk;
  logic [NB_EXT-1:0] bank_on;
  logic spi_bad, starved, spi_grant, ctrl_acc, spi_accept, bank_we;
  logic [WORD_BIT_WIDTH-1:0] bank_wdata, bank_mask, spi_word;
  logic [WORD_BIT_WIDTH-1:0] bank_rdata [NB_EXT];

  assign spi_chunk = spi_addr_q[CHUNK_LSB +: CHUNK_BITS];
  assign spi_row = spi_addr_q[ROW_LSB +: ROW_BITS];
  assign spi_bank = spi_addr_q[BANK_LSB +: BANK_BITS];
  assign ctrl_row = ctrl_address[ROW_BITS-1:0];
  assign ctrl_bank = ctrl_address[ROW_BITS +: BANK_BITS];

  // nonexistent bank slots extend as zero, so they read as powered down
  assign bank_on = NB_EXT'(~(bank_power_down | {NUM_BANKS{global_power_down}}));
  assign spi_bad = ((spi_addr_q >> PAD_LSB) != '0) || !bank_on[spi_bank];
  assign starved = state_q == PEND && wait_q == WAIT_BITS'(STARVE_LIMIT);
  assign spi_grant = state_q == PEND && !spi_bad && (!ctrl_chip_select || starved);
  assign ctrl_ready = !starved;
  assign ctrl_acc = ctrl_chip_select && ctrl_ready;
  assign spi_accept = state_q == IDLE && spi_req_valid && spi_code_is_bias;
  assign spi_req_ready = state_q == IDLE;

  // spi_grant and ctrl_acc are mutually exclusive, so one shared bank bus suffices
  assign bank_we = spi_grant ? spi_we_q : ctrl_write_enable;
  assign bank_row = spi_grant ? spi_row : ctrl_row;
  assign bank_wdata = spi_grant ? {CHUNKS{spi_wdata_q}} : ctrl_data_in;
  assign bank_mask = spi_grant ? WORD_BIT_WIDTH'(chunk_mask(32'(spi_chunk), MESSAGE_BIT_WIDTH)) : ctrl_mask;

  for (genvar b = 0; b < NB_EXT; b++) begin : g_bank
    if (b < NUM_BANKS) begin : g_sram
      bias_bank_sram #(.WIDTH(WORD_BIT_WIDTH), .DEPTH(ROWS_PER_BANK)) u_sram (
        .clk,
        .power_down_i(!bank_on[b]),
        .cs_i(bank_on[b] && ((ctrl_acc && ctrl_bank == BANK_BITS'(b)) || (spi_grant && spi_bank == BANK_BITS'(b)))),
        .we_i(bank_we),
        .addr_i(bank_row),
        .wdata_i(bank_wdata),
        .mask_i(bank_mask),
        .rdata_o(bank_rdata[b])
      );
    end else begin : g_none
      assign bank_rdata[b] = '0;
    end
  end

  assign spi_word = bank_rdata[spi_bank];
  assign spi_rsp_valid = spi_rsp_valid_q;
  assign spi_access_error = spi_err_q;
  assign spi_data_out = spi_data_q;
  assign ctrl_data_out = ctrl_rd_q ? bank_rdata[ctrl_bank_q] : ctrl_hold_q;

  // SPI request sequencing and starvation counting
  always_comb begin
    state_d = state_q;
    wait_d = '0;
    unique case (state_q)
      IDLE: state_d = spi_accept ? PEND : IDLE;
      PEND: begin
        if (spi_bad) state_d = IDLE;
        else if (spi_grant) state_d = spi_we_q ? IDLE : RDWAIT;
        else wait_d = wait_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
    end
  end

  // request capture, SPI response/error pulses and control read-data holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_we_q <= 1'b0;
      spi_addr_q <= '0;
      spi_wdata_q <= '0;
      spi_rsp_valid_q <= 1'b0;
      spi_err_q <= 1'b0;
      spi_data_q <= '0;
      ctrl_rd_q <= 1'b0;
      ctrl_bank_q <= '0;
      ctrl_hold_q <= '0;
    end else begin
      if (spi_accept) begin
        spi_we_q <= spi_req_write;
        spi_addr_q <= spi_address;
        spi_wdata_q <= spi_data_in;
      end
      spi_rsp_valid_q <= state_q == RDWAIT;
      spi_err_q <= state_q == PEND && spi_bad;
      if (state_q == RDWAIT) spi_data_q <= MESSAGE_BIT_WIDTH'(spi_word >> (spi_chunk * MESSAGE_BIT_WIDTH));
      ctrl_rd_q <= ctrl_acc && !ctrl_write_enable;
      if (ctrl_acc) ctrl_bank_q <= ctrl_bank;
      ctrl_hold_q <= ctrl_data_out;
    end
  end

endmodule

// File: tb/tb_managed_banked_bias_memory.sv
// tb_managed_banked_bias_memory: directed self-checking bench for the banked bias memory
module tb_managed_banked_bias_memory;

  logic clk, rst_n, global_power_down;
  logic [1:0] bank_power_down;
  logic spi_req_valid, spi_req_ready, spi_req_write, spi_code_is_bias;
  logic [13:0] spi_address;
  logic [31:0] spi_data_in, spi_data_out;
  logic spi_rsp_valid, spi_access_error, ctrl_ready;
  logic ctrl_chip_select, ctrl_write_enable;
  logic [5:0] ctrl_address;
  logic [63:0] ctrl_data_in, ctrl_mask, ctrl_data_out;
  int checks = 0;
  int fails = 0;

  managed_banked_bias_memory dut (
    .clk(clk), .rst_n(rst_n), .global_power_down(global_power_down), .bank_power_down(bank_power_down),
    .spi_req_valid(spi_req_valid), .spi_req_ready(spi_req_ready), .spi_req_write(spi_req_write),
    .spi_code_is_bias(spi_code_is_bias), .spi_address(spi_address), .spi_data_in(spi_data_in),
    .spi_rsp_valid(spi_rsp_valid), .spi_data_out(spi_data_out), .spi_access_error(spi_access_error),
    .ctrl_ready(ctrl_ready), .ctrl_chip_select(ctrl_chip_select), .ctrl_write_enable(ctrl_write_enable),
    .ctrl_address(ctrl_address), .ctrl_data_in(ctrl_data_in), .ctrl_mask(ctrl_mask), .ctrl_data_out(ctrl_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_issue(input logic we, input logic [13:0] addr, input logic [31:0] data);
    spi_req_valid = 1'b1;
    spi_code_is_bias = 1'b1;
    spi_req_write = we;
    spi_address = addr;
    spi_data_in = data;
    tick();
    spi_req_valid = 1'b0;
    spi_code_is_bias = 1'b0;
  endtask

  task automatic ctrl_op(input logic we, input logic [5:0] addr, input logic [63:0] data, input logic [63:0] mask);
    ctrl_chip_select = 1'b1;
    ctrl_write_enable = we;
    ctrl_address = addr;
    ctrl_data_in = data;
    ctrl_mask = mask;
    tick();
    ctrl_chip_select = 1'b0;
    ctrl_write_enable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (spi_req_ready !== 1'b1) begin fails++; $display("FAIL reset_spi_ready got %b want 1", spi_req_ready); end
    checks++; if (ctrl_ready !== 1'b1) begin fails++; $display("FAIL reset_ctrl_ready got %b want 1", ctrl_ready); end
    checks++; if (spi_rsp_valid !== 1'b0 || spi_access_error !== 1'b0) begin fails++; $display("FAIL reset_pulses got rsp=%b err=%b want 0 0", spi_rsp_valid, spi_access_error); end
    checks++; if (spi_data_out !== 32'h0 || ctrl_data_out !== 64'h0) begin fails++; $display("FAIL reset_data got spi=%h ctrl=%h want 0 0", spi_data_out, ctrl_data_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spi_write_read();
    ctrl_op(1'b1, 6'h23, 64'hA5A5_0000_0F0F_1234, {64{1'b1}});
    spi_issue(1'b1, 14'h0047, 32'hDEADBEEF);
    checks++; if (spi_req_ready !== 1'b0) begin fails++; $display("FAIL spi_ready_in_pend got %b want 0", spi_req_ready); end
    tick();
    checks++; if (spi_req_ready !== 1'b1) begin fails++; $display("FAIL spi_ready_after_write got %b want 1", spi_req_ready); end
    ctrl_op(1'b0, 6'h23, 64'h0, 64'h0);
    checks++; if (ctrl_data_out !== 64'hDEADBEEF_0F0F1234) begin fails++; $display("FAIL ctrl_sees_spi_write got %h want DEADBEEF0F0F1234", ctrl_data_out); end
    spi_issue(1'b0, 14'h0047, 32'h0);
    checks++; if (spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_rsp_edge1 got %b want 0", spi_rsp_valid); end
    tick();
    checks++; if (spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_rsp_edge2 got %b want 0", spi_rsp_valid); end
    tick();
    checks++; if (spi_rsp_valid !== 1'b1) begin fails++; $display("FAIL rd_rsp_edge3 got %b want 1", spi_rsp_valid); end
    checks++; if (spi_data_out !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h want DEADBEEF", spi_data_out); end
    tick();
    checks++; if (spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_rsp_pulse got %b want 0", spi_rsp_valid); end
    checks++; if (spi_data_out !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data_held got %h want DEADBEEF", spi_data_out); end
    checks++; if (ctrl_data_out !== 64'hDEADBEEF_0F0F1234) begin fails++; $display("FAIL ctrl_data_held got %h want DEADBEEF0F0F1234", ctrl_data_out); end
  endtask

  task automatic test_ctrl_mask();
    ctrl_op(1'b1, 6'h05, 64'h0, {64{1'b1}});
    ctrl_op(1'b1, 6'h05, 64'h1111_2222_3333_4444, 64'h0000_FFFF_0000_FFFF);
    ctrl_op(1'b0, 6'h05, 64'h0, 64'h0);
    checks++; if (ctrl_data_out !== 64'h0000_2222_0000_4444) begin fails++; $display("FAIL ctrl_masked_write got %h want 0000222200004444", ctrl_data_out); end
    tick();
    checks++; if (ctrl_data_out !== 64'h0000_2222_0000_4444) begin fails++; $display("FAIL ctrl_read_hold got %h want 0000222200004444", ctrl_data_out); end
  endtask

  task automatic test_starvation();
    ctrl_op(1'b1, 6'h07, 64'h0, {64{1'b1}});
    ctrl_chip_select = 1'b1;
    ctrl_write_enable = 1'b0;
    ctrl_address = 6'h05;
    spi_issue(1'b1, 14'h000E, 32'hCAFEF00D);
    checks++; if (ctrl_ready !== 1'b1) begin fails++; $display("FAIL starve_wait0 got %b want 1", ctrl_ready); end
    for (int i = 1; i <= 14; i++) begin
      tick();
      checks++; if (ctrl_ready !== 1'b1) begin fails++; $display("FAIL starve_wait%0d got %b want 1", i, ctrl_ready); end
    end
    tick();
    checks++; if (ctrl_ready !== 1'b0) begin fails++; $display("FAIL starve_limit got %b want 0", ctrl_ready); end
    checks++; if (ctrl_data_out !== 64'h0000_2222_0000_4444) begin fails++; $display("FAIL starve_ctrl_data got %h want 0000222200004444", ctrl_data_out); end
    tick();
    checks++; if (ctrl_ready !== 1'b1 || spi_req_ready !== 1'b1) begin fails++; $display("FAIL starve_release got ctrl=%b spi=%b want 1 1", ctrl_ready, spi_req_ready); end
    ctrl_chip_select = 1'b0;
    ctrl_op(1'b0, 6'h07, 64'h0, 64'h0);
    checks++; if (ctrl_data_out !== 64'h0000_0000_CAFE_F00D) begin fails++; $display("FAIL starve_write_landed got %h want 00000000CAFEF00D", ctrl_data_out); end
  endtask

  task automatic test_power_down();
    bank_power_down = 2'b10;
    spi_issue(1'b0, 14'h0047, 32'h0);
    tick();
    checks++; if (spi_access_error !== 1'b1 || spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL pd_error got err=%b rsp=%b want 1 0", spi_access_error, spi_rsp_valid); end
    tick();
    checks++; if (spi_access_error !== 1'b0 || spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL pd_error_pulse got err=%b rsp=%b want 0 0", spi_access_error, spi_rsp_valid); end
    tick();
    checks++; if (spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL pd_no_rsp got %b want 0", spi_rsp_valid); end
    ctrl_op(1'b0, 6'h23, 64'h0, 64'h0);
    checks++; if (ctrl_data_out !== 64'h0) begin fails++; $display("FAIL pd_ctrl_read got %h want 0", ctrl_data_out); end
    bank_power_down = 2'b00;
    global_power_down = 1'b1;
    spi_issue(1'b1, 14'h0047, 32'h0BADF00D);
    tick();
    checks++; if (spi_access_error !== 1'b1) begin fails++; $display("FAIL gpd_error got %b want 1", spi_access_error); end
    global_power_down = 1'b0;
    ctrl_op(1'b0, 6'h23, 64'h0, 64'h0);
    checks++; if (ctrl_data_out !== 64'hDEADBEEF_0F0F1234) begin fails++; $display("FAIL pd_retained got %h want DEADBEEF0F0F1234", ctrl_data_out); end
  endtask

  task automatic test_bad_address();
    spi_issue(1'b1, 14'h200E, 32'h12345678);
    tick();
    checks++; if (spi_access_error !== 1'b1) begin fails++; $display("FAIL pad_error got %b want 1", spi_access_error); end
    spi_issue(1'b1, 14'h008E, 32'h87654321);
    tick();
    checks++; if (spi_access_error !== 1'b1) begin fails++; $display("FAIL bank2_error got %b want 1", spi_access_error); end
    ctrl_op(1'b0, 6'h07, 64'h0, 64'h0);
    checks++; if (ctrl_data_out !== 64'h0000_0000_CAFE_F00D) begin fails++; $display("FAIL bad_addr_no_write got %h want 00000000CAFEF00D", ctrl_data_out); end
    spi_issue(1'b0, 14'h000E, 32'h0);
    tick();
    tick();
    checks++; if (spi_rsp_valid !== 1'b1 || spi_data_out !== 32'hCAFEF00D) begin fails++; $display("FAIL bad_addr_readback got rsp=%b data=%h want 1 CAFEF00D", spi_rsp_valid, spi_data_out); end
  endtask

  task automatic test_back_to_back();
    spi_issue(1'b1, 14'h000F, 32'h55AA55AA);
    tick();
    checks++; if (spi_req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", spi_req_ready); end
    spi_issue(1'b0, 14'h000F, 32'h0);
    tick();
    tick();
    checks++; if (spi_rsp_valid !== 1'b1 || spi_data_out !== 32'h55AA55AA) begin fails++; $display("FAIL b2b_read got rsp=%b data=%h want 1 55AA55AA", spi_rsp_valid, spi_data_out); end
    ctrl_op(1'b0, 6'h07, 64'h0, 64'h0);
    checks++; if (ctrl_data_out !== 64'h55AA55AA_CAFEF00D) begin fails++; $display("FAIL b2b_word got %h want 55AA55AACAFEF00D", ctrl_data_out); end
  endtask

  task automatic test_reset_pending();
    spi_issue(1'b1, 14'h000E, 32'hBAD0BAD0);
    rst_n = 1'b0;
    #1;
    checks++; if (spi_req_ready !== 1'b1) begin fails++; $display("FAIL rst_pend_ready got %b want 1", spi_req_ready); end
    checks++; if (ctrl_data_out !== 64'h0 || spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_pend_outputs got ctrl=%h rsp=%b want 0 0", ctrl_data_out, spi_rsp_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_pend_rsp1 got %b want 0", spi_rsp_valid); end
    tick();
    checks++; if (spi_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_pend_rsp2 got %b want 0", spi_rsp_valid); end
    ctrl_op(1'b0, 6'h07, 64'h0, 64'h0);
    checks++; if (ctrl_data_out !== 64'h55AA55AA_CAFEF00D) begin fails++; $display("FAIL rst_pend_no_write got %h want 55AA55AACAFEF00D", ctrl_data_out); end
  endtask

  initial begin
    rst_n = 1'b0;
    global_power_down = 1'b0;
    bank_power_down = 2'b00;
    spi_req_valid = 1'b0;
    spi_req_write = 1'b0;
    spi_code_is_bias = 1'b0;
    spi_address = '0;
    spi_data_in = '0;
    ctrl_chip_select = 1'b0;
    ctrl_write_enable = 1'b0;
    ctrl_address = '0;
    ctrl_data_in = '0;
    ctrl_mask = '0;
    test_reset();
    test_spi_write_read();
    test_ctrl_mask();
    test_starvation();
    test_power_down();
    test_bad_address();
    test_back_to_back();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
